des_round_ctrl: RTL and testbench

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

---
 rtl/des_round_ctrl_if.sv | 32 +++
 rtl/des_round_ctrl.sv | 80 ++++++++
 tb/tb_des_round_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/des_round_ctrl_if.sv
// des_round_ctrl_if: control/status bundle between the triple-DES sequencer and its user.
// The stall line exists only when DES_CTRL_STALL_EN is defined.
interface des_round_ctrl_if;
    logic       start;
    logic       mode;
    logic       abort;
`ifdef DES_CTRL_STALL_EN
    logic       stall;
`endif
    logic [4:0] round_sel;
    logic [1:0] key_sel;
    logic       dec;
    logic       load;
    logic       round_en;
    logic       last_round;
    logic       busy;
    logic       done;
    modport master (
`ifdef DES_CTRL_STALL_EN
        output stall,
`endif
        output start, mode, abort,
        input  round_sel, key_sel, dec, load, round_en, last_round, busy, done
    );
    modport slave (
`ifdef DES_CTRL_STALL_EN
        input  stall,
`endif
        input  start, mode, abort,
        output round_sel, key_sel, dec, load, round_en, last_round, busy, done
    );
endinterface

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: triple-DES round sequencer (3 stages x 16 rounds), all outputs registered.
// Optional hold input enabled by defining DES_CTRL_STALL_EN.
module des_round_ctrl (
    input  logic           clk,
    input  logic           rst,
    des_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
    state_t     state, state_n;
    logic [1:0] stage, stage_n;
    logic [3:0] cnt, cnt_n;
    logic       mode_r, mode_n, stall, hold, act, dec_n;
`ifdef DES_CTRL_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif
    always_comb begin
        state_n = state;
        stage_n = stage;
        cnt_n   = cnt;
        mode_n  = mode_r;
        hold    = stall && (state == LOAD || state == ROUND) && !bus.abort;
        if (state == IDLE && bus.start) begin
            state_n = LOAD;
            stage_n = 2'd0;
            cnt_n   = 4'd0;
            mode_n  = bus.mode;
        end else if ((state == LOAD || state == ROUND) && bus.abort) begin
            state_n = IDLE;
            stage_n = 2'd0;
            cnt_n   = 4'd0;
        end else if (state == LOAD && !hold) begin
            state_n = ROUND;
        end else if (state == ROUND && !hold) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd15) begin
                stage_n = stage + 2'd1;
                if (stage == 2'd2) begin
                    state_n = DONE;
                    stage_n = 2'd0;
                end
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
        act   = state_n == ROUND;
        // middle stage runs the opposite direction of the outer two
        dec_n = act && ((stage_n == 2'd1) ^ mode_n);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            stage          <= 2'd0;
            cnt            <= 4'd0;
            mode_r         <= 1'b0;
            bus.round_sel  <= 5'd1;
            bus.key_sel    <= 2'd0;
            bus.dec        <= 1'b0;
            bus.load       <= 1'b0;
            bus.round_en   <= 1'b0;
            bus.last_round <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_n;
            stage          <= stage_n;
            cnt            <= cnt_n;
            mode_r         <= mode_n;
            bus.round_sel  <= !act ? 5'd1 : dec_n ? 5'd16 - {1'b0, cnt_n} : {1'b0, cnt_n} + 5'd1;
            bus.key_sel    <= !act ? 2'd0 : mode_n ? 2'd2 - stage_n : stage_n;
            bus.dec        <= dec_n;
            bus.load       <= state_n == LOAD && !hold;
            bus.round_en   <= act && !hold;
            bus.last_round <= act && cnt_n == 4'd15;
            bus.busy       <= state_n != IDLE;
            bus.done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: table-driven directed checks of des_round_ctrl, plus abort/reset/stall sequences.
module tb_des_round_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    des_round_ctrl_if bus();
    des_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          m;
        int          cyc;
        logic [12:0] exp;
        logic [12:0] mask;
    } vec_t;

    localparam logic [12:0] full_m = 13'h1FFF;
    localparam logic [12:0] ctl_m  = 13'h001F;
    localparam logic [12:0] idle_v = {5'd1, 2'd0, 6'b000000};

    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    function automatic logic [12:0] pk(int rs, int ks, bit d, bit ld, bit re, bit lr, bit bz, bit dn);
        return {5'(rs), 2'(ks), d, ld, re, lr, bz, dn};
    endfunction

    function automatic vec_t mk(bit m, int c, logic [12:0] e, logic [12:0] mask);
        vec_t v;
        v.m = m; v.cyc = c; v.exp = e; v.mask = mask;
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {bus.round_sel, bus.key_sel, bus.dec, bus.load, bus.round_en,
                bus.last_round, bus.busy, bus.done};
    endfunction

    task automatic chk(string n, logic [12:0] a, logic [12:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chki(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(bit m, bit spur, int abort_at, int stall_at,
                          output int nlast, output int ndone, output int dcyc);
        bus.start = 1'b1;
        bus.mode  = m;
        step();
        bus.start = 1'b0;
        nlast = 0; ndone = 0; dcyc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.last_round) nlast++;
            if (bus.done) begin
                ndone++;
                dcyc = c;
            end
            if (abort_at < 0 && stall_at < 0 && !spur)
                foreach (tv[i])
                    if (tv[i].m == m && tv[i].cyc == c)
                        chk($sformatf("mode%0d_cyc%0d", m, c), outs() & tv[i].mask, tv[i].exp & tv[i].mask);
            if (c == abort_at + 1) chk("abort_idle", outs(), idle_v);
`ifdef DES_CTRL_STALL_EN
            if (stall_at >= 0 && c >= stall_at + 1 && c <= stall_at + 3)
                chk($sformatf("stall_hold_c%0d", c), outs(), pk(10, 0, 0, 0, 0, 0, 1, 0));
            if (stall_at >= 0 && c == stall_at + 4)
                chk("stall_resume", outs(), pk(11, 0, 0, 0, 1, 0, 1, 0));
            bus.stall = stall_at >= 0 && c >= stall_at && c < stall_at + 3;
`endif
            bus.start = spur && (c == 5 || c == 30);
            bus.abort = (c == abort_at);
            step();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef DES_CTRL_STALL_EN
        bus.stall = 1'b0;
`endif
    endtask

    int nl, nd, dc;

    initial begin
        tv.push_back(mk(0, 1,  pk(1, 0, 0, 1, 0, 0, 1, 0), ctl_m));
        tv.push_back(mk(0, 2,  pk(1, 0, 0, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(0, 9,  pk(8, 0, 0, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(0, 17, pk(16, 0, 0, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(0, 18, pk(16, 1, 1, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(0, 33, pk(1, 1, 1, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(0, 34, pk(1, 2, 0, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(0, 49, pk(16, 2, 0, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(0, 50, pk(1, 0, 0, 0, 0, 0, 1, 1), ctl_m));
        tv.push_back(mk(0, 51, idle_v, full_m));
        tv.push_back(mk(1, 1,  pk(1, 0, 0, 1, 0, 0, 1, 0), ctl_m));
        tv.push_back(mk(1, 2,  pk(16, 2, 1, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(1, 17, pk(1, 2, 1, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(1, 18, pk(1, 1, 0, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(1, 33, pk(16, 1, 0, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(1, 34, pk(16, 0, 1, 0, 1, 0, 1, 0), full_m));
        tv.push_back(mk(1, 49, pk(1, 0, 1, 0, 1, 1, 1, 0), full_m));
        tv.push_back(mk(1, 50, pk(1, 0, 0, 0, 0, 0, 1, 1), ctl_m));
        tv.push_back(mk(1, 51, idle_v, full_m));

        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.abort = 1'b0;
`ifdef DES_CTRL_STALL_EN
        bus.stall = 1'b0;
`endif
        repeat (2) step();
        rst = 1'b0;
        chk("reset_state", outs(), idle_v);

        run_op(0, 0, -1, -1, nl, nd, dc);
        chki("enc_last_count", nl, 3);
        chki("enc_done_count", nd, 1);
        chki("enc_done_cycle", dc, 50);

        run_op(1, 0, -1, -1, nl, nd, dc);
        chki("dec_last_count", nl, 3);
        chki("dec_done_cycle", dc, 50);

        run_op(0, 1, -1, -1, nl, nd, dc);
        chki("spur_done_count", nd, 1);
        chki("spur_done_cycle", dc, 50);

        run_op(0, 0, 24, -1, nl, nd, dc);
        chki("abort_done_count", nd, 0);
        run_op(0, 0, -1, -1, nl, nd, dc);
        chki("post_abort_done_cycle", dc, 50);

        bus.start = 1'b1;
        bus.mode  = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        bus.start = 1'b1;
        step();
        chk("rst_mid_op", outs(), idle_v);
        rst = 1'b0;
        bus.start = 1'b0;
        step();
        chk("rst_start_ignored", outs(), idle_v);
        run_op(0, 0, -1, -1, nl, nd, dc);
        chki("post_rst_done_cycle", dc, 50);

`ifdef DES_CTRL_STALL_EN
        run_op(0, 0, -1, 11, nl, nd, dc);
        chki("stall_done_count", nd, 1);
        chki("stall_done_cycle", dc, 53);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
